// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and constants for the D-stage hazard scoreboard:
// Tnew/Tuse encodings, the in-flight write shadow entry, and MD unit latencies.
package hazard_pkg;

  localparam int unsigned TW_DEF          = 2;
  localparam int unsigned MDW             = 4;
  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  localparam logic [TW_DEF-1:0] T0 = TW_DEF'(0);
  localparam logic [TW_DEF-1:0] T1 = TW_DEF'(1);
  localparam logic [TW_DEF-1:0] T2 = TW_DEF'(2);

  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef struct packed {
    logic [4:0]        wa;
    logic              we;
    logic [TW_DEF-1:0] tnew;
  } shadow_t;

  localparam shadow_t BUBBLE = '0;

  // A write to $0 is architecturally a no-op, so it never counts as a producer.
  function automatic logic is_live(shadow_t s);
    return s.we && (s.wa != ZERO_REG);
  endfunction

  function automatic shadow_t age_slot(shadow_t s);
    shadow_t r;
    r = s;
    if (r.tnew != T0) begin
      r.tnew = r.tnew - TW_DEF'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_md_busy_counter.sv
// Multiply/divide busy timer: loaded when a mult/div issues out of D,
// counts down to zero, cleared by flush or reset.
module md_busy_counter
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic flush_i,
  input  logic start_i,
  input  logic div_i,
  output logic busy_o
);

  localparam logic [MDW-1:0] MULT_LD = MDW'(MULT_CYCLES);
  localparam logic [MDW-1:0] DIV_LD  = MDW'(DIV_CYCLES);

  logic [MDW-1:0] cnt_q;
  logic [MDW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (flush_i) begin
      cnt_d = '0;
    end else if (start_i) begin
      cnt_d = div_i ? DIV_LD : MULT_LD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - MDW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard scoreboard: shadows in-flight GRF writes through E/M/W and
// stalls a D instruction whose operand Tuse is earlier than the producer's Tnew.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned TW          = TW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [4:0]    regRA1_D,
  input  logic [4:0]    regRA2_D,
  input  logic          use1_D,
  input  logic          use2_D,
  input  logic [TW-1:0] tuse1_D,
  input  logic [TW-1:0] tuse2_D,
  input  logic [4:0]    regWA_D,
  input  logic          regWE_D,
  input  logic [TW-1:0] tnew_D,
  input  logic          md_start_D,
  input  logic          md_div_D,
  input  logic          md_use_D,
  output logic          stall,
  output logic          md_busy,
  output logic          ready_E,
  output logic          ready_M
);

  shadow_t e_q, m_q, w_q;
  shadow_t e_d, m_d, w_d;

  logic stall_1, stall_2, stall_md;
  logic md_issue;

  // The youngest matching producer decides; older writes to the same register
  // are already superseded in the forwarding path.
  function automatic logic port_stall(logic rd_en, logic [4:0] ra, logic [TW-1:0] tuse,
                                      shadow_t e, shadow_t m, shadow_t w);
    logic s;
    s = 1'b0;
    if (rd_en) begin
      if (is_live(e) && (e.wa == ra)) begin
        s = (e.tnew > tuse);
      end else if (is_live(m) && (m.wa == ra)) begin
        s = (m.tnew > tuse);
      end else if (is_live(w) && (w.wa == ra)) begin
        s = (w.tnew > tuse);
      end
    end
    return s;
  endfunction

  always_comb begin
    stall_1  = port_stall(use1_D, regRA1_D, tuse1_D, e_q, m_q, w_q);
    stall_2  = port_stall(use2_D, regRA2_D, tuse2_D, e_q, m_q, w_q);
    stall_md = md_use_D && md_busy;
    stall    = stall_1 | stall_2 | stall_md;
  end

  // On flush the old M entry has already committed, so it still moves into W.
  always_comb begin
    if (stall) begin
      e_d = BUBBLE;
    end else begin
      e_d = '{wa: regWA_D, we: regWE_D, tnew: tnew_D};
    end
    m_d = age_slot(e_q);
    w_d = age_slot(m_q);
    if (flush) begin
      e_d = BUBBLE;
      m_d = BUBBLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= BUBBLE;
      m_q <= BUBBLE;
      w_q <= BUBBLE;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign md_issue = md_start_D && !stall;

  md_busy_counter #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_busy_counter (
    .clk_i   (clk),
    .reset_i (reset),
    .flush_i (flush),
    .start_i (md_issue),
    .div_i   (md_div_D),
    .busy_o  (md_busy)
  );

  assign ready_E = is_live(e_q) && (e_q.tnew == T0);
  assign ready_M = is_live(m_q) && (m_q.tnew == T0);

endmodule
